// File: rtl/valu_seq.sv
// valu_seq: walks one vector ALU instruction across the lane array in beats of
// VECTOR_LANES elements (register read, execute, writeback per beat).
module valu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int MICROOP_WIDTH = 5,
  parameter int VECTOR_LANES  = 8,
  parameter int MAX_BEATS     = 32,
  localparam int VLW   = $clog2(32*VECTOR_LANES)+1,
  localparam int BW    = $clog2(MAX_BEATS),
  localparam int VLMAX = MAX_BEATS*VECTOR_LANES,
  localparam int LDW   = VECTOR_LANES*DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [MICROOP_WIDTH-1:0] in_microop_i,
  input  logic [VLW-1:0]           in_vl_i,
  input  logic                     in_mask_en_i,
  input  logic [VLMAX-1:0]         in_mask_i,
  input  logic [DATA_WIDTH-1:0]    in_imm_i,
  output logic                     rd_req_o,
  output logic [BW-1:0]            rd_beat_o,
  input  logic [LDW-1:0]           rd_a_i,
  input  logic [LDW-1:0]           rd_b_i,
  output logic [VECTOR_LANES-1:0]  valu_valid_o,
  output logic [MICROOP_WIDTH-1:0] valu_microop_o,
  output logic [LDW-1:0]           valu_a_o,
  output logic [LDW-1:0]           valu_b_o,
  output logic [DATA_WIDTH-1:0]    valu_imm_o,
  input  logic [VECTOR_LANES-1:0]  valu_ready_i,
  input  logic [LDW-1:0]           valu_result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [BW-1:0]            wb_beat_o,
  output logic [VECTOR_LANES-1:0]  wb_lane_en_o,
  output logic [LDW-1:0]           wb_data_o,
  output logic                     done_o,
  output logic                     err_o
);
  localparam int EW = VLW+1;
  localparam int MW = $clog2(VLMAX);
  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;
  typedef struct packed {
    state_t                    state;
    logic [BW-1:0]             beat;
    logic [VLW-1:0]            vl;
    logic [MICROOP_WIDTH-1:0]  microop;
    logic                      mask_en;
    logic [VLMAX-1:0]          mask;
    logic [DATA_WIDTH-1:0]     imm;
    logic [VECTOR_LANES-1:0]   lane_en;
    logic [LDW-1:0]            data;
    logic                      sticky;
    logic                      done;
    logic                      err;
  } regs_t;
  regs_t r_q, r_d;
  logic [VECTOR_LANES-1:0] en;
  logic [LDW-1:0] res;
  logic [VLW-1:0] vl_clamp;
  logic legal, last;
  assign vl_clamp = in_vl_i > VLW'(VLMAX) ? VLW'(VLMAX) : in_vl_i;
  assign legal = int'(in_microop_i) inside {[1:10], 17, [19:24]};
  assign last = EW'(r_q.vl) <= EW'(r_q.beat) * EW'(VECTOR_LANES) + EW'(VECTOR_LANES);
  for (genvar l = 0; l < VECTOR_LANES; l++) begin : g_lane
    logic [EW-1:0] e;
    assign e = EW'(r_q.beat) * EW'(VECTOR_LANES) + EW'(l);
    assign en[l] = (e < EW'(r_q.vl)) && (!r_q.mask_en || r_q.mask[e[MW-1:0]]);
    assign res[l*DATA_WIDTH +: DATA_WIDTH] = en[l] ? valu_result_i[l*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  // Illegal or empty instructions complete straight from IDLE without touching the register file.
  always_comb begin
    r_d = r_q;
    r_d.done = 1'b0;
    r_d.err = 1'b0;
    case (r_q.state)
      IDLE: if (in_valid_i) begin
        r_d.vl = vl_clamp;
        r_d.microop = in_microop_i;
        r_d.mask_en = in_mask_en_i;
        r_d.mask = in_mask_i;
        r_d.imm = in_imm_i;
        r_d.beat = '0;
        r_d.sticky = 1'b0;
        r_d.state = (legal && vl_clamp != '0) ? RD : IDLE;
        r_d.done = !legal || vl_clamp == '0;
        r_d.err = !legal;
      end
      RD: r_d.state = EX;
      EX: begin
        r_d.state = WB;
        r_d.lane_en = en;
        r_d.data = res;
        r_d.sticky = r_q.sticky | |(en & ~valu_ready_i);
      end
      WB: if (wb_ready_i) begin
        r_d.state = last ? IDLE : RD;
        r_d.beat = last ? r_q.beat : r_q.beat + 1'b1;
        r_d.done = last;
        r_d.err = last & r_q.sticky;
      end
    endcase
    if (flush_i) r_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else r_q <= r_d;
  end
  assign in_ready_o     = r_q.state == IDLE;
  assign rd_req_o       = r_q.state == RD;
  assign rd_beat_o      = r_q.beat;
  assign valu_valid_o   = r_q.state == EX ? en : '0;
  assign valu_microop_o = r_q.microop;
  assign valu_a_o       = r_q.state == EX ? rd_a_i : '0;
  assign valu_b_o       = r_q.state == EX ? rd_b_i : '0;
  assign valu_imm_o     = r_q.imm;
  assign wb_valid_o     = r_q.state == WB;
  assign wb_beat_o      = r_q.beat;
  assign wb_lane_en_o   = r_q.lane_en;
  assign wb_data_o      = r_q.data;
  assign done_o         = r_q.done;
  assign err_o          = r_q.err;
endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq: randomized checks of valu_seq against an element-level reference model.
module tb_valu_seq;
  logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, in_ready_o;
  logic [4:0] in_microop_i = '0;
  logic [8:0] in_vl_i = '0;
  logic in_mask_en_i = 1'b0;
  logic [255:0] in_mask_i = '0;
  logic [31:0] in_imm_i = '0;
  logic rd_req_o;
  logic [4:0] rd_beat_o;
  logic [255:0] rd_a_i = '0, rd_b_i = '0;
  logic [7:0] valu_valid_o;
  logic [4:0] valu_microop_o;
  logic [255:0] valu_a_o, valu_b_o;
  logic [31:0] valu_imm_o;
  logic [7:0] valu_ready_i = '1;
  logic [255:0] valu_result_i;
  logic wb_valid_o, wb_ready_i = 1'b1;
  logic [4:0] wb_beat_o;
  logic [7:0] wb_lane_en_o;
  logic [255:0] wb_data_o;
  logic done_o, err_o;
  logic [31:0] src_a [256];
  logic [31:0] src_b [256];
  int checks = 0, errors = 0;
  int wc, dc;

  valu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_microop_i(in_microop_i), .in_vl_i(in_vl_i), .in_mask_en_i(in_mask_en_i), .in_mask_i(in_mask_i),
    .in_imm_i(in_imm_i), .rd_req_o(rd_req_o), .rd_beat_o(rd_beat_o), .rd_a_i(rd_a_i), .rd_b_i(rd_b_i),
    .valu_valid_o(valu_valid_o), .valu_microop_o(valu_microop_o), .valu_a_o(valu_a_o), .valu_b_o(valu_b_o),
    .valu_imm_o(valu_imm_o), .valu_ready_i(valu_ready_i), .valu_result_i(valu_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_beat_o(wb_beat_o), .wb_lane_en_o(wb_lane_en_o),
    .wb_data_o(wb_data_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    return op == 5'h01 ? a + b : op == 5'h02 ? a - b : op == 5'h11 ? a + imm : a ^ b ^ imm;
  endfunction

  always_comb begin
    valu_result_i = '0;
    for (int l = 0; l < 8; l++)
      valu_result_i[l*32 +: 32] = alu(valu_microop_o, valu_a_o[l*32 +: 32], valu_b_o[l*32 +: 32], valu_imm_o);
  end

  // register file: operands for the requested beat appear the cycle after the request
  always @(posedge clk)
    if (rd_req_o)
      for (int l = 0; l < 8; l++) begin
        rd_a_i[l*32 +: 32] <= src_a[int'(rd_beat_o)*8 + l];
        rd_b_i[l*32 +: 32] <= src_b[int'(rd_beat_o)*8 + l];
      end

  function automatic logic [7:0] en_of(input int bi, input int vlc, input logic me, input logic [255:0] mk);
    int e;
    for (int l = 0; l < 8; l++) begin
      e = bi*8 + l;
      en_of[l] = (e < vlc) && (!me || mk[e]);
    end
  endfunction

  function automatic logic [255:0] data_of(input int bi, input logic [7:0] en, input logic [4:0] op, input logic [31:0] imm);
    data_of = '0;
    for (int l = 0; l < 8; l++)
      if (en[l]) data_of[l*32 +: 32] = alu(op, src_a[bi*8+l], src_b[bi*8+l], imm);
  endfunction

  // stall: 0 = always ready, 1 = random ready, 2 = ready low for 5 cycles in beat 0
  task automatic run_op(input string nm, input logic [4:0] op, input int vl, input logic me, input logic [255:0] mk,
                        input logic [31:0] imm, input int stall, input int bad, output int wb_cyc, output int done_cyc);
    int vlc, nb, cyc, hs, rdc, stall_left;
    logic legal, exp_err, got_done, rdy;
    logic [7:0] een;
    legal = int'(op) inside {[1:10], 17, [19:24]};
    vlc = vl > 256 ? 256 : vl;
    nb = legal ? (vlc + 7) / 8 : 0;
    exp_err = !legal;
    for (int bi = 0; bi < nb; bi++)
      if (bad >= 0 && en_of(bi, vlc, me, mk)[bad]) exp_err = 1'b1;
    valu_ready_i = '1;
    if (bad >= 0) valu_ready_i[bad] = 1'b0;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", nm, in_ready_o); end
    in_valid_i = 1'b1; in_microop_i = op; in_vl_i = 9'(vl); in_mask_en_i = me; in_mask_i = mk; in_imm_i = imm;
    @(negedge clk);
    in_valid_i = 1'b0;
    cyc = 1; hs = 0; rdc = 0; wb_cyc = -1; done_cyc = -1; got_done = 1'b0;
    stall_left = stall == 2 ? 5 : 0;
    while (!got_done && cyc < 3000) begin
      if (rd_req_o) begin
        checks++;
        if (rdc != hs || rd_beat_o !== 5'(hs) || hs >= nb) begin
          errors++; $display("FAIL %s rd_req: beat %0d reads %0d handshakes %0d of %0d", nm, rd_beat_o, rdc, hs, nb);
        end
        rdc++;
      end
      if (valu_valid_o !== 8'h0) begin
        checks++;
        if (valu_valid_o !== en_of(hs, vlc, me, mk)) begin
          errors++; $display("FAIL %s valu_valid: got %h want %h", nm, valu_valid_o, en_of(hs, vlc, me, mk));
        end
      end
      if (wb_valid_o) begin
        if (wb_cyc < 0) wb_cyc = cyc;
        een = en_of(hs, vlc, me, mk);
        checks++;
        if (hs >= nb || wb_beat_o !== 5'(hs) || wb_lane_en_o !== een || wb_data_o !== data_of(hs, een, op, imm)) begin
          errors++;
          $display("FAIL %s wb beat%0d: got beat %0d en %h data %h want en %h data %h", nm, hs, wb_beat_o,
                   wb_lane_en_o, wb_data_o, een, data_of(hs, een, op, imm));
        end
        rdy = stall == 1 ? 1'($urandom_range(0, 1)) : stall_left == 0;
        if (stall_left > 0) stall_left--;
        wb_ready_i = rdy;
        if (rdy) hs++;
      end else wb_ready_i = 1'($urandom_range(0, 1));
      if (done_o) begin
        got_done = 1'b1; done_cyc = cyc;
        checks++;
        if (err_o !== exp_err || hs != nb || rdc != nb) begin
          errors++; $display("FAIL %s done: err %b want %b beats %0d reads %0d want %0d", nm, err_o, exp_err, hs, rdc, nb);
        end
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) begin
      checks++; errors++; $display("FAIL %s timeout: no done_o after %0d cycles", nm, cyc);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready_o !== 1'b1 || rd_req_o !== 1'b0 || valu_valid_o !== 8'h0 || wb_valid_o !== 1'b0 || wb_lane_en_o !== 8'h0 ||
        wb_data_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0 || valu_microop_o !== 5'h0 || valu_imm_o !== 32'h0) begin
      errors++; $display("FAIL reset: ready %b rd %b vv %h wbv %b en %h done %b err %b", in_ready_o, rd_req_o,
                         valu_valid_o, wb_valid_o, wb_lane_en_o, done_o, err_o);
    end
  endtask

  task automatic test_vadd();
    for (int l = 0; l < 8; l++) begin src_a[l] = 32'(l); src_b[l] = 32'd10; end
    run_op("vadd", 5'h01, 8, 1'b0, '0, 32'h0, 0, -1, wc, dc);
    checks++;
    if (wc != 3 || dc != 4) begin errors++; $display("FAIL vadd latency: wb %0d done %0d want 3 4", wc, dc); end
  endtask

  task automatic test_vsub();
    run_op("vsub", 5'h02, 20, 1'b0, '0, 32'h0, 0, -1, wc, dc);
    checks++;
    if (dc != 10) begin errors++; $display("FAIL vsub latency: done %0d want 10", dc); end
  endtask

  task automatic test_vaddi();
    logic [255:0] mk;
    mk = '0; mk[15:0] = 16'hAAAA;
    run_op("vaddi", 5'h11, 16, 1'b1, mk, 32'hFFFF_FFFF, 0, -1, wc, dc);
  endtask

  task automatic test_stall();
    run_op("stall", 5'h01, 16, 1'b0, '0, 32'h0, 2, -1, wc, dc);
    checks++;
    if (dc != 12) begin errors++; $display("FAIL stall latency: done %0d want 12", dc); end
  endtask

  task automatic test_no_exec();
    run_op("illegal", 5'h1F, 8, 1'b0, '0, 32'h0, 0, -1, wc, dc);
    checks++;
    if (dc != 1) begin errors++; $display("FAIL illegal latency: done %0d want 1", dc); end
    run_op("vl0", 5'h01, 0, 1'b0, '0, 32'h0, 0, -1, wc, dc);
    checks++;
    if (dc != 1) begin errors++; $display("FAIL vl0 latency: done %0d want 1", dc); end
    run_op("clamp", 5'h03, 400, 1'b0, '0, 32'h5, 0, -1, wc, dc);
  endtask

  task automatic test_lane_err();
    logic [255:0] mk;
    mk = '0; mk[7:0] = 8'hF7;
    run_op("lane_err", 5'h01, 8, 1'b0, '0, 32'h0, 0, 3, wc, dc);
    run_op("lane_err_masked", 5'h01, 8, 1'b1, mk, 32'h0, 0, 3, wc, dc);
    run_op("after_err", 5'h01, 8, 1'b0, '0, 32'h0, 0, -1, wc, dc);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 5'h04, 9, 1'b0, '0, 32'h7, 0, -1, wc, dc);
    run_op("b2b_1", 5'h18, 3, 1'b0, '0, 32'h9, 0, -1, wc, dc);
  endtask

  task automatic test_flush();
    int n;
    in_valid_i = 1'b1; in_microop_i = 5'h01; in_vl_i = 9'd32; in_mask_en_i = 1'b0; in_imm_i = '0;
    wb_ready_i = 1'b1; valu_ready_i = '1;
    @(negedge clk);
    in_valid_i = 1'b0;
    n = 0;
    while (!(wb_valid_o && wb_beat_o == 5'd1) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL flush setup: beat 1 writeback not seen"); end
    flush_i = 1'b1; in_valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || in_ready_o !== 1'b1 || done_o !== 1'b0 || wb_lane_en_o !== 8'h0 || wb_data_o !== '0) begin
      errors++; $display("FAIL flush state: wbv %b ready %b done %b en %h", wb_valid_o, in_ready_o, done_o, wb_lane_en_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || rd_req_o !== 1'b0) begin
        errors++; $display("FAIL flush idle: done %b rd_req %b want 0 0", done_o, rd_req_o);
      end
    end
    run_op("after_flush", 5'h02, 12, 1'b0, '0, 32'h0, 0, -1, wc, dc);
  endtask

  task automatic test_async_reset();
    int n;
    in_valid_i = 1'b1; in_microop_i = 5'h01; in_vl_i = 9'd24; in_mask_en_i = 1'b0; in_imm_i = 32'h3;
    wb_ready_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    n = 0;
    while (valu_valid_o == 8'h0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || rd_req_o !== 1'b0 || valu_valid_o !== 8'h0 || wb_valid_o !== 1'b0 || wb_lane_en_o !== 8'h0 ||
        wb_data_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0 || valu_imm_o !== 32'h0) begin
      errors++; $display("FAIL async_reset: ready %b rd %b vv %h wbv %b en %h imm %h", in_ready_o, rd_req_o,
                         valu_valid_o, wb_valid_o, wb_lane_en_o, valu_imm_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 5'h01, 8, 1'b0, '0, 32'h0, 0, -1, wc, dc);
  endtask

  task automatic test_random();
    logic [4:0] legal_ops [17] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                                   5'h11, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};
    logic [4:0] bad_ops [4] = '{5'h00, 5'h0B, 5'h12, 5'h1F};
    logic [4:0] op;
    logic [255:0] mk;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) mk[k*32 +: 32] = $urandom;
      op = $urandom_range(0, 7) == 0 ? bad_ops[$urandom_range(0, 3)] : legal_ops[$urandom_range(0, 16)];
      run_op($sformatf("rand%0d", i), op, int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)), mk, $urandom,
             1, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 7)) : -1, wc, dc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin src_a[i] = $urandom; src_b[i] = $urandom; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_vadd();
    test_vsub();
    test_vaddi();
    test_stall();
    test_no_exec();
    test_lane_err();
    test_back_to_back();
    for (int i = 0; i < 256; i++) begin src_a[i] = $urandom; src_b[i] = $urandom; end
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
